edge_scan_ctrl: RTL and testbench
=================================

EDGE_SCAN_CTRL -- requirements
Module: edge_scan_ctrl

Interface
REQ-001 Parameter WIDTH, default 640, pixels per line; SHALL be a multiple of 16 and at least 16.
REQ-002 Parameter HEIGHT, default 480, lines per frame; SHALL be at least 3.
REQ-003 Port clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port pixel_in  input  8  grayscale pixel.
REQ-006 Port pixel_valid  input  1  pixel_in is presented this cycle.
REQ-007 Port sof  input  1  start of frame; qualifies the pixel presented in the same cycle.
REQ-008 Port pixel_ready  output  1  block accepts the presented pixel this cycle.
REQ-009 Port edge_word  output  32  16 packed 2-bit results.
REQ-010 Port edge_valid  output  1  edge_word holds a complete word.
REQ-011 Port edge_ready  input  1  consumer takes edge_word this cycle.
REQ-012 Port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-013 Port busy  output  1  high while in state RUN.

Function
REQ-014 A pixel SHALL be accepted on a rising edge where pixel_valid and pixel_ready are both high.
REQ-015 pixel_ready SHALL equal (not edge_valid) or edge_ready.
REQ-016 The FSM SHALL have two states: IDLE (reset state) and RUN.
REQ-017 In IDLE, accepted pixels with sof low SHALL be discarded.
REQ-018 An accepted pixel with sof high SHALL move the FSM to RUN and be processed as row 0, column 0.
REQ-019 Row and column counters SHALL advance per accepted pixel in RUN. The column SHALL wrap at WIDTH-1 and increment the row.
REQ-020 When the pixel at (HEIGHT-1, WIDTH-1) is accepted, the FSM SHALL return to IDLE and frame_done SHALL pulse high in the next cycle.
REQ-021 An accepted sof in RUN SHALL restart the frame at (0,0) and discard any partially packed word. A completed word awaiting handoff SHALL NOT be discarded.
REQ-022 The block SHALL hold two previous lines in a line buffer (register or RAM) plus shift registers. For each accepted pixel at (r,c), it SHALL form the neighbourhood centred on (r-1,c-1):
- up = (r-2,c-1)
- down = (r,c-1)
- left = (r-1,c-2)
- right = (r-1,c)
REQ-023 Each neighbourhood SHALL be evaluated by an instance of kern_th_edge with block_in = {up,right,down,left}.
REQ-024 Required results (differences taken as 9-bit signed):
- thdx = (left - right) > 32
- thdy = (down - up) >= 32
- a negative difference SHALL never assert either flag.
REQ-025 The result for any pixel with r<2 or c<2 SHALL be forced to 00.
REQ-026 Exactly one 2-bit result SHALL be produced per accepted pixel in RUN, in input order. Result j of a word (j=0..15) SHALL occupy bits [2j+1:2j] as {thdy,thdx}.
REQ-027 Words SHALL align to column multiples of 16 and never straddle lines.
REQ-028 edge_valid SHALL rise on the clock edge that accepts the 16th pixel of a group, so edge_valid is high in the following cycle.
REQ-029 While edge_valid is high and edge_ready is low, edge_word and edge_valid SHALL be held stable.
REQ-030 If edge_valid and edge_ready are high and a new word completes in the same cycle, the new word SHALL be loaded and edge_valid SHALL remain high.
REQ-031 Line-buffer read data SHALL be held across stall cycles so no neighbour is lost or duplicated.

Reset
REQ-032 On reset, the block SHALL:
- enter IDLE
- clear the row, column and pack counters
- set edge_word=0, edge_valid=0, frame_done=0, busy=0
REQ-033 Line-buffer contents need not be cleared, because REQ-025 masks stale data.
REQ-034 Reset mid-frame SHALL abort the frame without emitting a partial word or pulsing frame_done.

Verification (WIDTH=16, HEIGHT=4, edge_ready=1 unless stated)
REQ-035 Reset: assert reset 2 cycles -> edge_valid=0, frame_done=0, busy=0, pixel_ready=1.
REQ-036 Flat frame, 64 pixels of 0x00 with sof on the first -> 4 words of 0x00000000; frame_done pulses once, the cycle after the 64th accept.
REQ-037 Vertical step, rows 0-1 = 0 and rows 2-3 = 32 -> words 0x00000000, 0x00000000, 0xAAAAAAA0, 0xAAAAAAA0. With 31 instead of 32, all words are 0.
REQ-038 Horizontal step, columns 0-7 = 33 and columns 8-15 = 0 in every row -> words 2 and 3 = 0x00050000, words 0 and 1 = 0. With 32 instead of 33, all words are 0.
REQ-039 Backpressure: hold edge_ready=0 for 5 cycles when word 0 completes -> edge_word stable, pixel_ready=0, no pixel dropped; the full output sequence is identical to REQ-036.
REQ-040 Restart: sof asserted at pixel 20 of a frame -> pixels 16-19 are discarded. Counting restarts at (0,0) and the frame completes 64 accepts later with a single frame_done.

Source files
------------

// File: rtl/edge_scan_ctrl.sv
// Streaming 3x3-cross edge scanner: accepts a raster of 8-bit pixels, evaluates a
// thresholded gradient around each pixel one line and one column behind the input,
// and packs the 2-bit results into 32-bit words aligned to 16-pixel column groups.

// Threshold kernel: block_in = {up, right, down, left}; differences are 9-bit signed.
module kern_th_edge (
  input  logic [31:0] block_in,
  output logic        thdx,
  output logic        thdy
);

  logic        [7:0] up, right, down, left;
  logic signed [8:0] dx, dy;

  assign {up, right, down, left} = block_in;
  assign dx   = $signed({1'b0, left}) - $signed({1'b0, right});
  assign dy   = $signed({1'b0, down}) - $signed({1'b0, up});
  assign thdx = (dx >  9'sd32);
  assign thdy = (dy >= 9'sd32);

endmodule

module edge_scan_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  input  logic        sof,
  output logic        pixel_ready,
  output logic [31:0] edge_word,
  output logic        edge_valid,
  input  logic        edge_ready,
  output logic        frame_done,
  output logic        busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic            frame_done_q, frame_done_d;
  logic [31:0]     pack_q, word_nx;
  logic [31:0]     edge_word_q;
  logic            edge_valid_q;

  // Two previous lines plus the neighbour shift registers; pure data, never reset.
  logic [7:0]      lb1_q [WIDTH];
  logic [7:0]      lb2_q [WIDTH];
  logic [7:0]      down_q, up_q, rr1_q, rr2_q;

  logic            accept, proc, last_px, mask, thdx, thdy;
  logic [RW-1:0]   r_cur;
  logic [CW-1:0]   c_cur;
  logic [3:0]      slot;
  logic [4:0]      bit_idx;
  logic [1:0]      res;
  logic [7:0]      right_w;
  logic [31:0]     nbhd;

  assign pixel_ready = ~edge_valid_q | edge_ready;
  assign accept      = pixel_valid & pixel_ready;
  // A sof pixel is always taken as (0,0); otherwise only RUN processes pixels.
  assign proc        = accept & (sof | (state_q == RUN));
  assign r_cur       = sof ? '0 : row_q;
  assign c_cur       = sof ? '0 : col_q;
  assign last_px     = (r_cur == ROW_LAST) && (c_cur == COL_LAST);
  assign slot        = c_cur[3:0];
  assign bit_idx     = {slot, 1'b0};

  // Neighbourhood centred on (r-1, c-1); right comes straight from the line buffer.
  assign right_w = lb1_q[c_cur];
  assign nbhd    = {up_q, right_w, down_q, rr2_q};

  kern_th_edge u_kern (
    .block_in (nbhd),
    .thdx     (thdx),
    .thdy     (thdy)
  );

  // Border pixels have an incomplete or stale neighbourhood, so they report no edge.
  assign mask = (r_cur < ROW_TWO) || (c_cur < COL_TWO);
  assign res  = mask ? 2'b00 : {thdy, thdx};

  assign edge_word  = edge_word_q;
  assign edge_valid = edge_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == RUN);

  // FSM state and frame-done pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next state: enter or stay in RUN on each processed pixel, leave after the last one.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    if (proc) begin
      if (last_px) begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
      end else begin
        state_d      = RUN;
      end
    end
  end

  // Raster position of the next pixel to be processed.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (proc) begin
      if (c_cur == COL_LAST) begin
        col_q <= '0;
        row_q <= last_px ? '0 : r_cur + RW'(1);
      end else begin
        col_q <= c_cur + CW'(1);
        row_q <= r_cur;
      end
    end
  end

  // Line buffers and neighbour shift registers advance only on a processed pixel,
  // so their contents stay put across stalls.
  always_ff @(posedge clock) begin
    if (proc) begin
      lb1_q[c_cur] <= pixel_in;
      lb2_q[c_cur] <= lb1_q[c_cur];
      down_q       <= pixel_in;
      up_q         <= lb2_q[c_cur];
      rr1_q        <= right_w;
      rr2_q        <= rr1_q;
    end
  end

  // Insert the current result into its slot of the word being built.
  always_comb begin
    word_nx = pack_q;
    word_nx[bit_idx +: 2] = res;
  end

  // Partial word accumulator; every slot is rewritten before a word completes,
  // so a restart simply overwrites any leftover partial content.
  always_ff @(posedge clock) begin
    if (reset) begin
      pack_q <= '0;
    end else if (proc) begin
      pack_q <= (slot == 4'hF) ? '0 : word_nx;
    end
  end

  // Output word register with valid/ready handoff; a new word may replace one being taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      edge_word_q  <= '0;
      edge_valid_q <= 1'b0;
    end else if (proc && (slot == 4'hF)) begin
      edge_word_q  <= word_nx;
      edge_valid_q <= 1'b1;
    end else if (edge_ready) begin
      edge_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Directed bench for edge_scan_ctrl on a 16x4 frame: table of frame patterns with
// hand-computed output words, plus sequences for reset, backpressure and restart.
module tb_edge_scan_ctrl;

  localparam int W = 16;
  localparam int H = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  pixel_in = 8'd0;
  logic        pixel_valid = 1'b0;
  logic        sof = 1'b0;
  logic        edge_ready = 1'b1;
  logic        pixel_ready, edge_valid, frame_done, busy;
  logic [31:0] edge_word;

  edge_scan_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock       (clock),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .sof         (sof),
    .pixel_ready (pixel_ready),
    .edge_word   (edge_word),
    .edge_valid  (edge_valid),
    .edge_ready  (edge_ready),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // kind 0: rows >= 2 get hi, else lo.  kind 1: columns < edgec get hi, else lo.
  typedef struct packed {
    logic             kind;
    logic [7:0]       lo;
    logic [7:0]       hi;
    logic [4:0]       edgec;
    logic [3:0][31:0] w;
  } vec_t;

  vec_t        tbl [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] got [$];
  int          fd_cnt = 0;

  // Handshakes and frame_done pulses, observed on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (edge_valid && edge_ready) got.push_back(edge_word);
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic kind, input logic [7:0] lo, input logic [7:0] hi,
                              input logic [4:0] edgec, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
    vec_t v;
    v.kind = kind; v.lo = lo; v.hi = hi; v.edgec = edgec;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  function automatic logic [7:0] pix(input vec_t v, input int r, input int c);
    if (v.kind == 1'b0) return (r >= 2) ? v.hi : v.lo;
    return (c < int'(v.edgec)) ? v.hi : v.lo;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] p, input logic s);
    int n;
    pixel_in = p; sof = s; pixel_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!pixel_ready && n < 100) begin
      n++;
      @(negedge clock);
    end
    if (!pixel_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: pixel_ready stayed 0, required 1");
    end
    @(posedge clock); #1;
    pixel_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; pixel_valid = 1'b0; sof = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Full frame with sof on the first pixel; optionally stall the consumer after word stall_w.
  task automatic run_frame(input string tag, input vec_t v, input int stall_w);
    int i;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        i = r * W + c;
        send(pix(v, r, c), (i == 0));
        if (i == 0) chk($sformatf("%s_busy_run", tag), busy, 1'b1);
        if (stall_w >= 0 && i == stall_w * 16 + 15 && i < W * H - 1) begin
          edge_ready = 1'b0;
          pixel_in = pix(v, (i + 1) / W, (i + 1) % W); pixel_valid = 1'b1;
          for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("%s_stall%0d_ready", tag, k), pixel_ready, 1'b0);
            chk($sformatf("%s_stall%0d_valid", tag, k), edge_valid, 1'b1);
            chk($sformatf("%s_stall%0d_word", tag, k), edge_word, v.w[stall_w]);
          end
          @(posedge clock); #1;
          edge_ready = 1'b1;
        end
      end
    end
    @(negedge clock);
    chk($sformatf("%s_frame_done_pulse", tag), frame_done, 1'b1);
    chk($sformatf("%s_busy_after", tag), busy, 1'b0);
    @(negedge clock);
    chk($sformatf("%s_frame_done_low", tag), frame_done, 1'b0);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_words(input string tag, input vec_t v, input int off);
    logic [31:0] a;
    chk($sformatf("%s_word_count", tag), got.size(), 32'(4 + off));
    for (int k = 0; k < 4; k++) begin
      a = (off + k < got.size()) ? got[off + k] : 32'hxxxxxxxx;
      chk($sformatf("%s_word%0d", tag, k), a, v.w[k]);
    end
    chk($sformatf("%s_frame_done_count", tag), fd_cnt, 32'd1);
  endtask

  initial begin
    tbl[0] = mk(1'b0, 8'd0,   8'd0,   5'd0,  32'h0, 32'h0, 32'h0,         32'h0);
    tbl[1] = mk(1'b0, 8'd0,   8'd32,  5'd0,  32'h0, 32'h0, 32'hAAAAAAA0, 32'hAAAAAAA0);
    tbl[2] = mk(1'b0, 8'd0,   8'd31,  5'd0,  32'h0, 32'h0, 32'h0,         32'h0);
    tbl[3] = mk(1'b0, 8'd200, 8'd0,   5'd0,  32'h0, 32'h0, 32'h0,         32'h0);
    tbl[4] = mk(1'b1, 8'd0,   8'd33,  5'd8,  32'h0, 32'h0, 32'h00050000, 32'h00050000);
    tbl[5] = mk(1'b1, 8'd0,   8'd32,  5'd8,  32'h0, 32'h0, 32'h0,         32'h0);
    tbl[6] = mk(1'b1, 8'd0,   8'd100, 5'd4,  32'h0, 32'h0, 32'h00000500, 32'h00000500);
    tbl[7] = mk(1'b1, 8'd200, 8'd0,   5'd8,  32'h0, 32'h0, 32'h0,         32'h0);

    // Reset state
    do_reset();
    @(negedge clock);
    chk("reset_edge_valid",  edge_valid,  1'b0);
    chk("reset_frame_done",  frame_done,  1'b0);
    chk("reset_busy",        busy,        1'b0);
    chk("reset_pixel_ready", pixel_ready, 1'b1);
    chk("reset_edge_word",   edge_word,   32'h0);

    // Pixels without sof in IDLE are dropped
    got.delete(); fd_cnt = 0;
    for (int i = 0; i < 20; i++) send(8'hFF, 1'b0);
    repeat (3) @(negedge clock);
    chk("idle_busy",        busy,       1'b0);
    chk("idle_word_count",  got.size(), 32'd0);
    chk("idle_frame_done",  fd_cnt,     32'd0);

    // Pattern table
    for (int t = 0; t < 8; t++) begin
      got.delete(); fd_cnt = 0;
      run_frame($sformatf("vec%0d", t), tbl[t], -1);
      check_words($sformatf("vec%0d", t), tbl[t], 0);
    end

    // Backpressure on word 0 of a flat frame, and on word 2 of the vertical step
    got.delete(); fd_cnt = 0;
    run_frame("bp_flat", tbl[0], 0);
    check_words("bp_flat", tbl[0], 0);
    got.delete(); fd_cnt = 0;
    run_frame("bp_vert", tbl[1], 2);
    check_words("bp_vert", tbl[1], 0);

    // Restart: sof arrives at pixel 20 of a frame
    got.delete(); fd_cnt = 0;
    for (int i = 0; i < 20; i++) send(8'(8'hF0 + i), (i == 0));
    chk("restart_pre_frame_done", fd_cnt, 32'd0);
    run_frame("restart", tbl[1], -1);
    chk("restart_first_word", (got.size() > 0) ? got[0] : 32'hxxxxxxxx, 32'h0);
    check_words("restart", tbl[1], 1);

    // Reset in mid-frame: no partial word, no frame_done, then a clean frame
    got.delete(); fd_cnt = 0;
    for (int i = 0; i < 24; i++) send(8'd77, (i == 0));
    do_reset();
    @(negedge clock);
    chk("midreset_busy",       busy,       1'b0);
    chk("midreset_edge_valid", edge_valid, 1'b0);
    chk("midreset_frame_done", frame_done, 1'b0);
    repeat (3) @(negedge clock);
    chk("midreset_word_count", got.size(), 32'd1);
    chk("midreset_fd_count",   fd_cnt,     32'd0);
    got.delete(); fd_cnt = 0;
    run_frame("post_reset", tbl[4], -1);
    check_words("post_reset", tbl[4], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
